texture_buffer_loader: RTL and testbench

TEXTURE_BUFFER_LOADER -- requirements
Module: texture_buffer_loader

---
 rtl/texture_buffer_loader.sv | 163 ++++++++++++++++
 tb/tb_texture_buffer_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/texture_buffer_loader.sv
// texture_buffer_loader: streams texels from the command parser into a
// texture bank while the texture unit reads the active bank.
// Ports: aclk/reset (async, active-high); s_texture_axis_* inbound beats;
// tmuIdle permits a bank swap; texelAddr/texelData 1-cycle read path;
// activeBank, loadBusy, overflow status.
// Macro TEXTURE_BUFFER_DOUBLE_BANK_EN: two banks with swap on tmuIdle;
// undefined gives a single bank written in place, activeBank tied to 0.
module texture_buffer_loader #(
  parameter int STREAM_WIDTH = 16,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    s_texture_axis_tvalid,
  output logic                    s_texture_axis_tready,
  input  logic                    s_texture_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_texture_axis_tdata,
  input  logic                    tmuIdle,
  input  logic [ADDR_WIDTH-1:0]   texelAddr,
  output logic [STREAM_WIDTH-1:0] texelData,
  output logic                    activeBank,
  output logic                    loadBusy,
  output logic                    overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWAP_PENDING
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_nx;
  logic                    full, full_nx;
  logic                    busy, busy_nx;
  logic                    ovf, ovf_nx;
  logic                    ready, ready_nx;
  logic [STREAM_WIDTH-1:0] rd_data;
  logic                    beat;
  logic                    wr_en;

`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
  localparam int BANKS = 2;
  logic                  bank, bank_nx;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  assign wr_ptr     = {~bank, wr_addr};
  assign rd_ptr     = {bank, texelAddr};
  assign activeBank = bank;
`else
  localparam int BANKS = 1;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  unused_tmu_idle;
  assign wr_ptr          = wr_addr;
  assign rd_ptr          = texelAddr;
  assign activeBank      = 1'b0;
  assign unused_tmu_idle = tmuIdle;
`endif

  logic [STREAM_WIDTH-1:0] mem [BANKS*DEPTH];

  assign beat  = s_texture_axis_tvalid & ready;
  // once the last word has been written, further beats are dropped
  assign wr_en = beat & ~full;

  always_comb begin
    state_nx   = state;
    wr_addr_nx = wr_addr;
    full_nx    = full;
    busy_nx    = busy;
    ovf_nx     = ovf;
`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
    bank_nx    = bank;
`endif
    unique case (state)
      IDLE, LOAD: begin
        if (beat) begin
          if (state == IDLE) begin
            busy_nx  = 1'b1;
            ovf_nx   = 1'b0;
            state_nx = LOAD;
          end
          if (full) begin
            ovf_nx = 1'b1;
          end
          if (s_texture_axis_tlast) begin
            wr_addr_nx = '0;
            full_nx    = 1'b0;
`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
            state_nx   = SWAP_PENDING;
`else
            state_nx   = IDLE;
            busy_nx    = 1'b0;
`endif
          end else if (wr_addr == LAST_ADDR) begin
            full_nx = 1'b1;
          end else begin
            wr_addr_nx = wr_addr + 1'b1;
          end
        end
      end
      SWAP_PENDING: begin
`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
        if (tmuIdle) begin
          state_nx = IDLE;
          bank_nx  = ~bank;
          busy_nx  = 1'b0;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
    // registered so tready stays low through reset and rises on the
    // first edge after release
    ready_nx = (state_nx != SWAP_PENDING);
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_addr <= '0;
      full    <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      ready   <= 1'b0;
      rd_data <= '0;
`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
      bank    <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      wr_addr <= wr_addr_nx;
      full    <= full_nx;
      busy    <= busy_nx;
      ovf     <= ovf_nx;
      ready   <= ready_nx;
      // uses the pre-swap bank on a swap edge
      rd_data <= mem[rd_ptr];
`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
      bank    <= bank_nx;
`endif
    end
  end

  // bank RAM keeps its contents across reset
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_texture_axis_tdata;
    end
  end

  assign s_texture_axis_tready = ready;
  assign texelData             = rd_data;
  assign loadBusy              = busy;
  assign overflow              = ovf;

endmodule

// File: tb/tb_texture_buffer_loader.sv
// tb_texture_buffer_loader: scoreboard bench for texture_buffer_loader.
// Transaction-level model predicts every cycle; monitor checks outputs.
module tb_texture_buffer_loader;

  localparam int SW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;
`ifdef TEXTURE_BUFFER_DOUBLE_BANK_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tlast = 1'b0;
  logic [SW-1:0] tdata = '0;
  logic          tmu_idle = 1'b0;
  logic [AW-1:0] taddr = '0;
  logic [SW-1:0] texel_data;
  logic          active_bank;
  logic          load_busy;
  logic          overflow;

  always #5 aclk = ~aclk;

  texture_buffer_loader #(
    .STREAM_WIDTH(SW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .aclk                 (aclk),
    .reset                (reset),
    .s_texture_axis_tvalid(tvalid),
    .s_texture_axis_tready(tready),
    .s_texture_axis_tlast (tlast),
    .s_texture_axis_tdata (tdata),
    .tmuIdle              (tmu_idle),
    .texelAddr            (taddr),
    .texelData            (texel_data),
    .activeBank           (active_bank),
    .loadBusy             (load_busy),
    .overflow             (overflow)
  );

  typedef struct {
    logic          rd;
    logic [SW-1:0] data;
    logic          rdy;
    logic          bank;
    logic          busy;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // behavioural model: texture memory plus load bookkeeping
  logic [SW-1:0] m_mem   [2][DEPTH];
  bit            m_known [2][DEPTH];
  int            m_ptr;
  bit            m_bank, m_busy, m_ovf, m_pending, m_ready, m_loading;

  task automatic check(input string name, input logic [SW-1:0] act,
                       input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_bank    = 1'b0;
    m_busy    = 1'b0;
    m_ovf     = 1'b0;
    m_pending = 1'b0;
    m_ready   = 1'b0;
    m_loading = 1'b0;
  endtask

  // one clock: drive inputs, predict the edge, queue the expectation
  task automatic step(input bit v, input bit last, input logic [SW-1:0] d,
                      input bit idle, input logic [AW-1:0] a);
    exp_t e;
    int   wb;
    tvalid   = v;
    tlast    = last;
    tdata    = d;
    tmu_idle = idle;
    taddr    = a;
    e.rd     = m_known[m_bank][a];
    e.data   = m_mem[m_bank][a];
    if (m_pending) begin
      if (idle) begin
        m_bank    = !m_bank;
        m_busy    = 1'b0;
        m_pending = 1'b0;
      end
    end else if (v && m_ready) begin
      if (!m_loading) begin
        m_loading = 1'b1;
        m_busy    = 1'b1;
        m_ovf     = 1'b0;
      end
      wb = DB ? int'(!m_bank) : 0;
      if (m_ptr < DEPTH) begin
        m_mem[wb][m_ptr]   = d;
        m_known[wb][m_ptr] = 1'b1;
        m_ptr++;
      end else begin
        m_ovf = 1'b1;
      end
      if (last) begin
        m_ptr     = 0;
        m_loading = 1'b0;
        if (DB) m_pending = 1'b1;
        else    m_busy    = 1'b0;
      end
    end
    m_ready = !m_pending;
    e.rdy   = m_ready;
    e.bank  = m_bank;
    e.busy  = m_busy;
    e.ovf   = m_ovf;
    sb.push_back(e);
    @(negedge aclk);
  endtask

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(DEPTH - 1, 0));
  endfunction

  task automatic send(input int n, input logic [SW-1:0] base,
                      input logic [SW-1:0] inc, input bit with_last);
    logic [SW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + SW'(i) * inc;
      step(1'b1, with_last && (i == n - 1), d, 1'b0, raddr());
    end
  endtask

  // hold tmuIdle low, then raise it with addr 5 on the swap cycle
  task automatic swap_after(input int hold);
    repeat (hold) step(1'b0, 1'b0, '0, 1'b0, raddr());
    step(1'b0, 1'b0, '0, 1'b1, AW'(5));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, AW'(i));
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    model_reset();
    #1;
    check("rst_tready", SW'(tready), '0);
    check("rst_bank", SW'(active_bank), '0);
    check("rst_busy", SW'(load_busy), '0);
    check("rst_ovf", SW'(overflow), '0);
    check("rst_texel", texel_data, '0);
    @(negedge aclk);
    @(negedge aclk);
    check("rst_tready_hold", SW'(tready), '0);
    check("rst_busy_hold", SW'(load_busy), '0);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        check("tready", SW'(tready), SW'(e.rdy));
        check("activeBank", SW'(active_bank), SW'(e.bank));
        check("loadBusy", SW'(load_busy), SW'(e.busy));
        check("overflow", SW'(overflow), SW'(e.ovf));
        if (e.rd) check("texelData", texel_data, e.data);
      end
    end
  end

  initial begin : driver
    int            left;
    bit            v, acc;
    logic [SW-1:0] d;
    foreach (m_known[b, i]) m_known[b][i] = 1'b0;
    @(negedge aclk);
    do_reset();
    // first cycle after release: tready still low, beat ignored
    step(1'b1, 1'b0, 16'hdead, 1'b0, '0);
    // overflowing texture: 10 beats into 8 words, last dropped
    send(10, 16'h00a0, 16'h0001, 1'b1);
    swap_after(2);
    // four-beat texture, tmuIdle held low for 10 cycles
    send(4, 16'h1111, 16'h1111, 1'b1);
    swap_after(10);
    // abandoned load, then a fresh load from address 0
    send(2, 16'h5500, 16'h0001, 1'b0);
    do_reset();
    send(4, 16'h7700, 16'h0011, 1'b1);
    swap_after(0);
    // single-beat texture
    send(1, 16'hbeef, 16'h0000, 1'b1);
    swap_after(1);
    // randomized traffic
    left = $urandom_range(12, 1);
    repeat (600) begin
      v   = ($urandom_range(3, 0) != 0);
      acc = v && m_ready;
      d   = SW'($urandom);
      step(v, left == 1, d, $urandom_range(2, 0) == 0, raddr());
      if (acc) begin
        left--;
        if (left == 0) left = $urandom_range(12, 1);
      end
    end
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, raddr());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
